pipe_track_chain: RTL and testbench
===================================

Name:
pipe_track_chain

Overview:
- Parametrised in-flight tracker for the pipeline back end. It replaces the fixed EXE/MEM/WB dest and WB_EN shadow registers, and the separate hazard and forwarding compare logic, with one DEPTH-stage elastic chain.
- Each slot holds dest, wb_en, result data and a data-valid flag.
- The chain gives priority forwarding lookups for NSRC source operands, raises a stall when the producer's data is not yet known (load-use), and supports selective per-stage flush and downstream backpressure.

Parameters:
- DEPTH, 3: number of tracked stages (0 = youngest).
- DATA_W, 32: result width (`WORD_LEN).
- ADDR_W, 5: register address width (`REG_FILE_ADDR_LEN).
- NSRC, 2: number of lookup ports.
- LATE_STAGE, 1: stage index where late (memory) data is filled; range 0..DEPTH-1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  new entry offered
- in_ready  out  1  stage 0 can accept
- in_dest  in  ADDR_W  destination register
- in_wb_en  in  1  entry writes back
- in_data  in  DATA_W  result, if known at entry
- in_data_vld  in  1  in_data is valid
- late_vld  in  1  late result for the LATE_STAGE entry
- late_data  in  DATA_W  late result value
- flush_mask  in  DEPTH  per-stage discard
- out_valid  out  1  oldest entry present
- out_ready  in  1  consumer accepts
- out_dest  out  ADDR_W  oldest entry dest
- out_wb_en  out  1  oldest entry wb_en
- out_data  out  DATA_W  oldest entry data
- src_addr  in  NSRC*ADDR_W  lookup addresses
- fwd_hit  out  NSRC  matching producer in flight
- fwd_data  out  NSRC*DATA_W  value from youngest match
- fwd_stall  out  NSRC  youngest match has no data yet

Behaviour:
- Reset (sync, rst=1 at edge): all valid and data_vld flags cleared. out_valid=0, out_dest/out_data/out_wb_en=0, fwd_hit=0, fwd_stall=0, in_ready=1. Reset mid-operation drops every entry.
- Slot k is "empty" if !valid[k] or flush_mask[k]; flush is evaluated on slot contents at cycle start.
- Hold rule: the LATE_STAGE slot with valid && !data_vld && !late_vld cannot advance.
- adv[DEPTH-1] = out_ready && !hold. adv[k] = !hold && (empty[k+1] || adv[k+1]). Ready propagates combinationally from the tail.
- in_ready = empty[0] || adv[0]. An entry is accepted when in_valid && in_ready; stage 0 captures it at the edge.
- Each entry moves one stage per advancing cycle; minimum latency in to out_valid is DEPTH cycles.
- Flushed slots are discarded, never move and never appear at the output. An unflushed upstream entry may move into a flushed slot in the same cycle.
- Late fill: when late_vld and the LATE_STAGE slot is valid && !data_vld, data is captured with data_vld=1. If that slot also advances this cycle, the filled data travels with it. late_vld is ignored otherwise.
- out_* is driven straight from slot DEPTH-1; out_valid = valid[DEPTH-1] && !flush_mask[DEPTH-1].
- Lookup is combinational on registered slot state:
  - match = valid && !flush_mask && wb_en && dest==src && src!=0.
  - The lowest-index (youngest) match wins.
  - fwd_hit=1 on any match; fwd_data = winner.data; fwd_stall = winner.!data_vld.
  - No match gives hit=0, stall=0, data=0.
- Address 0 never matches.
- in_* is never looked up in the same cycle it is offered.

Optional Feature:
- PIPE_TRACK_LATE_FWD_EN defined: if the winning match is the LATE_STAGE slot with !data_vld and late_vld=1 this cycle, fwd_data=late_data and fwd_stall=0. This removes one load-use bubble.
- Undefined: late data becomes visible to lookups only from the next cycle.

Decomposition:
- `WORD_LEN and `REG_FILE_ADDR_LEN come from defines.v and serve as parameter defaults.
- Add `PIPE_TRACK_DEPTH to defines.v.
- Sub-module pipe_track_slot: one stage register holding valid, dest, wb_en, data and data_vld, with load/advance/flush/fill inputs. Instantiate it DEPTH times via generate.
- The lookup priority mux stays in the top.

Test Plan:
1. Reset: rst=1 then 0 -> out_valid=0, in_ready=1, fwd_hit=00.
2. Forward priority:
   - Push dest=5 data=0x1234 vld, then dest=5 data=0x5678 vld; src0=5 -> hit=1, fwd_data=0x5678, stall=0.
   - After the younger entry is flushed, the same lookup returns 0x1234.
3. Load-use:
   - Push dest=7 in_data_vld=0; src1=7 -> fwd_stall=1.
   - Hold late_vld=0 for 4 cycles: entry waits at stage 1, stage 0 fills, in_ready=0.
   - late_vld=1 with 0xBEEF -> next cycle fwd_data=0xBEEF, stall=0, chain advances.
   - With PIPE_TRACK_LATE_FWD_EN: same-cycle hit, stall=0.
4. Backpressure: stream 6 entries with out_ready=0 for 5 cycles -> exactly 3 held, in_ready=0, no loss, outputs retire in push order once out_ready=1.
5. Flush: all slots full, flush_mask=3'b011, out_ready=1 -> stage 2 retires, stages 0/1 empty next cycle, lookups for their dests -> hit=0.
6. Zero register: push dest=0 wb_en=1; src0=0 -> hit=0. Also push dest=9 wb_en=0; src0=9 -> hit=0.

Source files
------------

// File: rtl/pipe_track_chain_pkg.sv
// Shared parameter defaults and lookup helpers for the pipe_track_chain in-flight tracker.
// Optional build macro used by the top: PIPE_TRACK_LATE_FWD_EN (same-cycle late-data forwarding).
`ifndef WORD_LEN
`define WORD_LEN 32
`endif
`ifndef REG_FILE_ADDR_LEN
`define REG_FILE_ADDR_LEN 5
`endif
`ifndef PIPE_TRACK_DEPTH
`define PIPE_TRACK_DEPTH 3
`endif

package pipe_track_chain_pkg;

  localparam int PT_DATA_W     = `WORD_LEN;
  localparam int PT_ADDR_W     = `REG_FILE_ADDR_LEN;
  localparam int PT_DEPTH      = `PIPE_TRACK_DEPTH;
  localparam int PT_NSRC       = 2;
  localparam int PT_LATE_STAGE = 1;

  typedef struct packed {
    logic hit;
    logic stall;
  } fwd_flags_t;

  // A winning producer stalls the consumer only while its result is still unknown.
  function automatic fwd_flags_t fwd_flags(input logic hit, input logic data_vld);
    fwd_flags_t f;
    f.hit   = hit;
    f.stall = hit && !data_vld;
    return f;
  endfunction

endpackage

// File: rtl/pipe_track_slot.sv
// One stage of the in-flight chain: valid, dest, wb_en, result data and its valid flag.
// Load wins over clear (advance/flush), which wins over a late-data fill.
module pipe_track_slot
  import pipe_track_chain_pkg::*;
#(
  parameter int DATA_W = PT_DATA_W,
  parameter int ADDR_W = PT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic              i_fill,
  input  logic [ADDR_W-1:0] i_dest,
  input  logic              i_wb_en,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_data_vld,
  input  logic [DATA_W-1:0] i_late_data,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_dest,
  output logic              o_wb_en,
  output logic [DATA_W-1:0] o_data,
  output logic              o_data_vld
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_dest;
  logic              r_wb_en;
  logic [DATA_W-1:0] r_data;
  logic              r_data_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_dest     <= '0;
      r_wb_en    <= 1'b0;
      r_data     <= '0;
      r_data_vld <= 1'b0;
    end else if (i_load) begin
      r_valid    <= 1'b1;
      r_dest     <= i_dest;
      r_wb_en    <= i_wb_en;
      r_data     <= i_data;
      r_data_vld <= i_data_vld;
    end else if (i_clear) begin
      r_valid    <= 1'b0;
      r_data_vld <= 1'b0;
    end else if (i_fill) begin
      r_data     <= i_late_data;
      r_data_vld <= 1'b1;
    end
  end

  assign o_valid    = r_valid;
  assign o_dest     = r_dest;
  assign o_wb_en    = r_wb_en;
  assign o_data     = r_data;
  assign o_data_vld = r_data_vld;

endmodule

// File: rtl/pipe_track_chain.sv
// DEPTH-stage elastic in-flight tracker with priority forwarding, load-use stall, flush and backpressure.
// Build option: define PIPE_TRACK_LATE_FWD_EN to forward late_data to lookups in the cycle it arrives.
module pipe_track_chain
  import pipe_track_chain_pkg::*;
#(
  parameter int DEPTH      = PT_DEPTH,
  parameter int DATA_W     = PT_DATA_W,
  parameter int ADDR_W     = PT_ADDR_W,
  parameter int NSRC       = PT_NSRC,
  parameter int LATE_STAGE = PT_LATE_STAGE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      in_dest,
  input  logic                   in_wb_en,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_data_vld,
  input  logic                   late_vld,
  input  logic [DATA_W-1:0]      late_data,
  input  logic [DEPTH-1:0]       flush_mask,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_W-1:0]      out_dest,
  output logic                   out_wb_en,
  output logic [DATA_W-1:0]      out_data,
  input  logic [NSRC*ADDR_W-1:0] src_addr,
  output logic [NSRC-1:0]        fwd_hit,
  output logic [NSRC*DATA_W-1:0] fwd_data,
  output logic [NSRC-1:0]        fwd_stall
);

  logic [DEPTH-1:0]  w_valid;
  logic [DEPTH-1:0]  w_wb_en;
  logic [DEPTH-1:0]  w_data_vld;
  logic [ADDR_W-1:0] w_dest [DEPTH];
  logic [DATA_W-1:0] w_data [DEPTH];

  logic [DEPTH-1:0]  w_empty;
  logic [DEPTH-1:0]  w_adv;
  logic [DEPTH-1:0]  w_load;
  logic [DEPTH-1:0]  w_clear;
  logic [DEPTH-1:0]  w_fill;
  logic [ADDR_W-1:0] w_in_dest [DEPTH];
  logic [DEPTH-1:0]  w_in_wb_en;
  logic [DATA_W-1:0] w_in_data [DEPTH];
  logic [DEPTH-1:0]  w_in_data_vld;

  logic w_hold;
  logic w_late_fill;
  logic w_adv_acc;

  assign w_hold      = w_valid[LATE_STAGE] && !w_data_vld[LATE_STAGE] && !late_vld;
  assign w_late_fill = late_vld && w_valid[LATE_STAGE] && !w_data_vld[LATE_STAGE];

  // Ready ripples from the tail; a waiting load freezes the whole chain.
  always_comb begin
    w_adv            = '0;
    w_adv_acc        = out_ready && !w_hold;
    w_adv[DEPTH-1]   = w_adv_acc;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      w_adv_acc = !w_hold && (w_empty[k+1] || w_adv_acc);
      w_adv[k]  = w_adv_acc;
    end
  end

  assign in_ready = w_empty[0] || w_adv[0];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      if (gi == 0) begin : g_head
        assign w_load[gi]        = in_valid && in_ready;
        assign w_in_dest[gi]     = in_dest;
        assign w_in_wb_en[gi]    = in_wb_en;
        assign w_in_data[gi]     = in_data;
        assign w_in_data_vld[gi] = in_data_vld;
      end else begin : g_body
        localparam bit FROM_LATE = ((gi - 1) == LATE_STAGE);
        // A filled entry that advances in the same cycle carries the late value along.
        assign w_load[gi]        = w_adv[gi-1] && !w_empty[gi-1];
        assign w_in_dest[gi]     = w_dest[gi-1];
        assign w_in_wb_en[gi]    = w_wb_en[gi-1];
        assign w_in_data[gi]     = (FROM_LATE && w_late_fill) ? late_data : w_data[gi-1];
        assign w_in_data_vld[gi] = w_data_vld[gi-1] || (FROM_LATE && w_late_fill);
      end

      assign w_empty[gi] = !w_valid[gi] || flush_mask[gi];
      assign w_clear[gi] = w_adv[gi] || flush_mask[gi];
      assign w_fill[gi]  = (gi == LATE_STAGE) && w_late_fill;

      pipe_track_slot #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
      ) u_slot (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load[gi]),
        .i_clear     (w_clear[gi]),
        .i_fill      (w_fill[gi]),
        .i_dest      (w_in_dest[gi]),
        .i_wb_en     (w_in_wb_en[gi]),
        .i_data      (w_in_data[gi]),
        .i_data_vld  (w_in_data_vld[gi]),
        .i_late_data (late_data),
        .o_valid     (w_valid[gi]),
        .o_dest      (w_dest[gi]),
        .o_wb_en     (w_wb_en[gi]),
        .o_data      (w_data[gi]),
        .o_data_vld  (w_data_vld[gi])
      );
    end
  endgenerate

  assign out_valid = w_valid[DEPTH-1] && !flush_mask[DEPTH-1];
  assign out_dest  = w_dest[DEPTH-1];
  assign out_wb_en = w_wb_en[DEPTH-1];

  generate
    if (LATE_STAGE == DEPTH - 1) begin : g_out_late
      assign out_data = w_late_fill ? late_data : w_data[DEPTH-1];
    end else begin : g_out_reg
      assign out_data = w_data[DEPTH-1];
    end
  endgenerate

  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_lookup
      logic [ADDR_W-1:0] w_src;
      logic              w_hit;
      logic              w_dvld;
      logic [DATA_W-1:0] w_win_data;
      fwd_flags_t        w_flags;
`ifdef PIPE_TRACK_LATE_FWD_EN
      logic              w_late_win;
`endif

      assign w_src = src_addr[gi*ADDR_W +: ADDR_W];

      // Scan oldest to youngest so the youngest match overwrites.
      always_comb begin
        w_hit      = 1'b0;
        w_dvld     = 1'b0;
        w_win_data = '0;
`ifdef PIPE_TRACK_LATE_FWD_EN
        w_late_win = 1'b0;
`endif
        for (int k = DEPTH - 1; k >= 0; k--) begin
          if (w_valid[k] && !flush_mask[k] && w_wb_en[k] &&
              (w_dest[k] == w_src) && (w_src != '0)) begin
            w_hit      = 1'b1;
            w_dvld     = w_data_vld[k];
            w_win_data = w_data[k];
`ifdef PIPE_TRACK_LATE_FWD_EN
            w_late_win = (k == LATE_STAGE);
`endif
          end
        end
`ifdef PIPE_TRACK_LATE_FWD_EN
        if (w_late_win && !w_dvld && late_vld) begin
          w_win_data = late_data;
          w_dvld     = 1'b1;
        end
`endif
      end

      assign w_flags                      = fwd_flags(w_hit, w_dvld);
      assign fwd_hit[gi]                  = w_flags.hit;
      assign fwd_stall[gi]                = w_flags.stall;
      assign fwd_data[gi*DATA_W +: DATA_W] = w_win_data;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_track_chain.sv
// Directed self-checking bench for pipe_track_chain (DEPTH=3, LATE_STAGE=1, two lookup ports).
module tb_pipe_track_chain;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_dest;
  logic        in_wb_en;
  logic [31:0] in_data;
  logic        in_data_vld;
  logic        late_vld;
  logic [31:0] late_data;
  logic [2:0]  flush_mask;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_dest;
  logic        out_wb_en;
  logic [31:0] out_data;
  logic [9:0]  src_addr;
  logic [1:0]  fwd_hit;
  logic [63:0] fwd_data;
  logic [1:0]  fwd_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_track_chain #(
    .DEPTH(3), .DATA_W(32), .ADDR_W(5), .NSRC(2), .LATE_STAGE(1)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_dest(in_dest), .in_wb_en(in_wb_en),
    .in_data(in_data), .in_data_vld(in_data_vld),
    .late_vld(late_vld), .late_data(late_data), .flush_mask(flush_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_dest(out_dest),
    .out_wb_en(out_wb_en), .out_data(out_data),
    .src_addr(src_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_dest = 0; in_wb_en = 0; in_data = 0; in_data_vld = 0;
    late_vld = 0; late_data = 0; flush_mask = 0; out_ready = 0; src_addr = 0;
  endtask

  task automatic push(input logic [4:0] d, input logic w, input logic [31:0] v, input logic dv);
    in_valid = 1; in_dest = d; in_wb_en = w; in_data = v; in_data_vld = dv;
    tick();
    in_valid = 0;
    $display("push dest=%0d wb_en=%0b data=%h data_vld=%0b", d, w, v, dv);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; tick(); tick(); rst = 0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (fwd_hit !== 2'b00) begin errors++; $display("FAIL reset_fwd_hit got=%b exp=00", fwd_hit); end
    checks++; if (fwd_stall !== 2'b00) begin errors++; $display("FAIL reset_fwd_stall got=%b exp=00", fwd_stall); end
    checks++; if (out_data !== 32'h0 || out_dest !== 5'd0 || out_wb_en !== 1'b0) begin
      errors++; $display("FAIL reset_out_fields got=%h/%0d/%0b exp=0/0/0", out_data, out_dest, out_wb_en); end
    // reset while entries are in flight
    push(5'd5, 1, 32'h11, 1);
    push(5'd6, 1, 32'h22, 1);
    src_addr = {5'd6, 5'd5}; #1;
    checks++; if (fwd_hit !== 2'b11) begin errors++; $display("FAIL midrst_pre_hit got=%b exp=11", fwd_hit); end
    rst = 1; tick(); rst = 0; #1;
    checks++; if (fwd_hit !== 2'b00) begin errors++; $display("FAIL midrst_hit got=%b exp=00", fwd_hit); end
    out_ready = 1; tick(); tick(); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%0b exp=0", out_valid); end
    idle_inputs();
  endtask

  task automatic test_fwd_priority();
    idle_inputs();
    push(5'd5, 1, 32'h1234, 1);
    push(5'd5, 1, 32'h5678, 1);
    src_addr = {5'd5, 5'd5}; #1;
    checks++; if (fwd_hit !== 2'b11) begin errors++; $display("FAIL prio_hit got=%b exp=11", fwd_hit); end
    checks++; if (fwd_data[31:0] !== 32'h5678) begin errors++; $display("FAIL prio_data0 got=%h exp=5678", fwd_data[31:0]); end
    checks++; if (fwd_data[63:32] !== 32'h5678) begin errors++; $display("FAIL prio_data1 got=%h exp=5678", fwd_data[63:32]); end
    checks++; if (fwd_stall !== 2'b00) begin errors++; $display("FAIL prio_stall got=%b exp=00", fwd_stall); end
    flush_mask = 3'b001; #1;
    checks++; if (fwd_data[31:0] !== 32'h1234) begin errors++; $display("FAIL prio_flush_data got=%h exp=1234", fwd_data[31:0]); end
    tick(); flush_mask = 3'b000; #1;
    checks++; if (fwd_hit[0] !== 1'b1 || fwd_data[31:0] !== 32'h1234) begin
      errors++; $display("FAIL prio_after_flush got=%0b/%h exp=1/1234", fwd_hit[0], fwd_data[31:0]); end
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h1234) begin
      errors++; $display("FAIL prio_out got=%0b/%h exp=1/1234", out_valid, out_data); end
    out_ready = 1; tick(); out_ready = 0; #1;
    checks++; if (out_valid !== 1'b0 || fwd_hit !== 2'b00) begin
      errors++; $display("FAIL prio_drain got=%0b/%b exp=0/00", out_valid, fwd_hit); end
    idle_inputs();
  endtask

  task automatic test_load_use();
    idle_inputs();
    out_ready = 1;
    push(5'd7, 1, 32'h0, 0);
    src_addr = {5'd7, 5'd3}; #1;
    checks++; if (fwd_hit[1] !== 1'b1 || fwd_stall[1] !== 1'b1) begin
      errors++; $display("FAIL lu_first got=%0b/%0b exp=1/1", fwd_hit[1], fwd_stall[1]); end
    in_valid = 1; in_dest = 5'd3; in_wb_en = 1; in_data = 32'h33; in_data_vld = 1;
    tick();
    in_dest = 5'd4; in_data = 32'h44; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_hold_ready got=%0b exp=0", in_ready); end
    checks++; if (fwd_stall[1] !== 1'b1) begin errors++; $display("FAIL lu_hold_stall got=%0b exp=1", fwd_stall[1]); end
    checks++; if (fwd_hit[0] !== 1'b1 || fwd_data[31:0] !== 32'h33 || fwd_stall[0] !== 1'b0) begin
      errors++; $display("FAIL lu_stage0_fwd got=%0b/%h/%0b exp=1/33/0", fwd_hit[0], fwd_data[31:0], fwd_stall[0]); end
    for (int i = 0; i < 3; i++) tick();
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL lu_still_held got=%0b/%0b exp=0/0", in_ready, out_valid); end
    late_vld = 1; late_data = 32'hBEEF; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_release_ready got=%0b exp=1", in_ready); end
`ifdef PIPE_TRACK_LATE_FWD_EN
    checks++; if (fwd_stall[1] !== 1'b0 || fwd_data[63:32] !== 32'hBEEF) begin
      errors++; $display("FAIL lu_late_fwd got=%0b/%h exp=0/beef", fwd_stall[1], fwd_data[63:32]); end
`else
    checks++; if (fwd_stall[1] !== 1'b1) begin errors++; $display("FAIL lu_late_nofwd got=%0b exp=1", fwd_stall[1]); end
`endif
    tick();
    in_valid = 0; late_vld = 0; #1;
    checks++; if (out_valid !== 1'b1 || out_dest !== 5'd7 || out_data !== 32'hBEEF) begin
      errors++; $display("FAIL lu_out_L got=%0b/%0d/%h exp=1/7/beef", out_valid, out_dest, out_data); end
    checks++; if (fwd_data[63:32] !== 32'hBEEF || fwd_stall[1] !== 1'b0 || fwd_hit[1] !== 1'b1) begin
      errors++; $display("FAIL lu_fwd_filled got=%h/%0b exp=beef/0", fwd_data[63:32], fwd_stall[1]); end
    tick();
    checks++; if (out_dest !== 5'd3 || out_data !== 32'h33) begin
      errors++; $display("FAIL lu_out_n1 got=%0d/%h exp=3/33", out_dest, out_data); end
    tick();
    checks++; if (out_dest !== 5'd4 || out_data !== 32'h44) begin
      errors++; $display("FAIL lu_out_n2 got=%0d/%h exp=4/44", out_dest, out_data); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lu_empty got=%0b exp=0", out_valid); end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int got = 0;
    logic acc;
    idle_inputs();
    for (int c = 0; c < 5; c++) begin
      in_valid = 1; in_wb_en = 1; in_data_vld = 1;
      in_dest = 5'(10 + sent); in_data = 32'hA0 + 32'(sent);
      #1; acc = in_ready;
      tick();
      if (acc) sent++;
    end
    checks++; if (sent !== 3) begin errors++; $display("FAIL bp_accepted got=%0d exp=3", sent); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got=%0b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b1 || out_dest !== 5'd10) begin
      errors++; $display("FAIL bp_head got=%0b/%0d exp=1/10", out_valid, out_dest); end
    out_ready = 1;
    for (int c = 0; c < 20 && got < 6; c++) begin
      in_valid = (sent < 6);
      in_dest = 5'(10 + sent); in_data = 32'hA0 + 32'(sent);
      #1;
      if (out_valid) begin
        checks++; if (out_dest !== 5'(10 + got) || out_data !== 32'hA0 + 32'(got)) begin
          errors++; $display("FAIL bp_order got=%0d/%h exp=%0d/%h", out_dest, out_data, 10 + got, 32'hA0 + got); end
        $display("retire dest=%0d data=%h", out_dest, out_data);
        got++;
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) sent++;
    end
    checks++; if (got !== 6 || sent !== 6) begin errors++; $display("FAIL bp_count got=%0d/%0d exp=6/6", got, sent); end
    idle_inputs();
    tick();
  endtask

  task automatic test_flush();
    idle_inputs();
    push(5'd20, 1, 32'h200, 1);
    push(5'd21, 1, 32'h201, 1);
    push(5'd22, 1, 32'h202, 1);
    src_addr = {5'd22, 5'd21}; #1;
    checks++; if (fwd_hit !== 2'b11) begin errors++; $display("FAIL fl_pre_hit got=%b exp=11", fwd_hit); end
    flush_mask = 3'b011; out_ready = 1; #1;
    checks++; if (fwd_hit !== 2'b00) begin errors++; $display("FAIL fl_masked_hit got=%b exp=00", fwd_hit); end
    checks++; if (out_valid !== 1'b1 || out_dest !== 5'd20 || out_data !== 32'h200) begin
      errors++; $display("FAIL fl_retire got=%0b/%0d/%h exp=1/20/200", out_valid, out_dest, out_data); end
    tick();
    flush_mask = 3'b000; out_ready = 0; #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL fl_after got=%0b/%0b exp=0/1", out_valid, in_ready); end
    checks++; if (fwd_hit !== 2'b00) begin errors++; $display("FAIL fl_after_hit got=%b exp=00", fwd_hit); end
    src_addr = {5'd22, 5'd20}; #1;
    checks++; if (fwd_hit !== 2'b00) begin errors++; $display("FAIL fl_retired_hit got=%b exp=00", fwd_hit); end
    idle_inputs();
  endtask

  task automatic test_zero_reg();
    idle_inputs();
    push(5'd0, 1, 32'hDEAD, 1);
    push(5'd9, 0, 32'h99, 1);
    src_addr = {5'd9, 5'd0}; #1;
    checks++; if (fwd_hit !== 2'b00 || fwd_stall !== 2'b00 || fwd_data !== 64'h0) begin
      errors++; $display("FAIL zr_lookup got=%b/%b/%h exp=00/00/0", fwd_hit, fwd_stall, fwd_data); end
    out_ready = 1; tick();
    checks++; if (out_valid !== 1'b1 || out_dest !== 5'd0 || out_wb_en !== 1'b1) begin
      errors++; $display("FAIL zr_out0 got=%0b/%0d/%0b exp=1/0/1", out_valid, out_dest, out_wb_en); end
    tick();
    checks++; if (out_dest !== 5'd9 || out_wb_en !== 1'b0 || out_data !== 32'h99) begin
      errors++; $display("FAIL zr_out9 got=%0d/%0b/%h exp=9/0/99", out_dest, out_wb_en, out_data); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL zr_empty got=%0b exp=0", out_valid); end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_fwd_priority();
    test_load_use();
    test_backpressure();
    test_flush();
    test_zero_reg();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
